// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of a 5-stage RISC-V pipeline. Holds the
//            PC and selects the next PC (sequential or EX redirect). Drives
//            the zero-latency instruction memory and registers the returned
//            word into the IF/ID pipeline register. Honours the hazard-unit
//            stall and flush controls, flags out-of-range and misaligned
//            fetches, and counts delivered instructions.
// Ports    : clk, rst_n (sync, active-low)
//            stall_f, stall_d, flush_d, pc_src_e, pc_target_e   - control in
//            imem_addr / imem_rd                                 - memory
//            pc_f, fault_f                                       - IF view
//            instr_d, pc_d, pc_plus4_d, valid_d                  - IF/ID
//            fetch_err, misalign_err, fetch_count                - status
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                  ADDRESS   = 32,
  parameter int                  INSTR     = 32,
  parameter logic [ADDRESS-1:0]  RESET_PC  = 32'h0000_0000,
  parameter int                  MEM_DEPTH = 21,
  parameter logic [INSTR-1:0]    NOP       = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [ADDRESS-1:0] pc_target_e,
  output logic [ADDRESS-1:0] imem_addr,
  input  logic [INSTR-1:0]   imem_rd,
  output logic [ADDRESS-1:0] pc_f,
  output logic [INSTR-1:0]   instr_d,
  output logic [ADDRESS-1:0] pc_d,
  output logic [ADDRESS-1:0] pc_plus4_d,
  output logic               valid_d,
  output logic               fault_f,
  output logic               fetch_err,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);

  // Word-index limit compared against pc[ADDRESS-1:2].
  localparam logic [ADDRESS-3:0] c_mem_depth = (ADDRESS-2)'(MEM_DEPTH);
  localparam logic [ADDRESS-1:0] c_four      = ADDRESS'(4);

  logic [ADDRESS-1:0] pc_q,        pc_d_nx;
  logic [INSTR-1:0]   instr_id_q,  instr_id_d;
  logic [ADDRESS-1:0] pc_id_q,     pc_id_d;
  logic [ADDRESS-1:0] pc4_id_q,    pc4_id_d;
  logic               valid_id_q,  valid_id_d;
  logic               ferr_q,      ferr_d;
  logic               merr_q,      merr_d;
  logic [31:0]        count_q,     count_d;

  logic               w_fault;
  logic [ADDRESS-1:0] w_pc_plus4;

  assign w_fault    = (pc_q[ADDRESS-1:2] >= c_mem_depth);
  assign w_pc_plus4 = pc_q + c_four;

  always_comb begin
    pc_d_nx    = pc_q;
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    ferr_d     = ferr_q;
    merr_d     = merr_q;
    count_d    = count_q;

    // Next PC: redirect beats stall; a fault does not stop sequential advance.
    if (pc_src_e) begin
      pc_d_nx = {pc_target_e[ADDRESS-1:2], 2'b00};
      if (pc_target_e[1:0] != 2'b00) begin
        merr_d = 1'b1;
      end
    end else if (!stall_f) begin
      pc_d_nx = w_pc_plus4;
    end

    // IF/ID register: flush beats stall; a faulting fetch inserts a bubble
    // but still records where it happened.
    if (flush_d) begin
      instr_id_d = NOP;
      pc_id_d    = '0;
      pc4_id_d   = '0;
      valid_id_d = 1'b0;
    end else if (!stall_d) begin
      pc_id_d  = pc_q;
      pc4_id_d = w_pc_plus4;
      if (w_fault) begin
        instr_id_d = NOP;
        valid_id_d = 1'b0;
        ferr_d     = 1'b1;
      end else begin
        instr_id_d = imem_rd;
        valid_id_d = 1'b1;
        count_d    = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_id_q <= NOP;
      pc_id_q    <= '0;
      pc4_id_q   <= '0;
      valid_id_q <= 1'b0;
      ferr_q     <= 1'b0;
      merr_q     <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d_nx;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
      ferr_q     <= ferr_d;
      merr_q     <= merr_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc_f         = pc_q;
  assign fault_f      = w_fault;
  assign instr_d      = instr_id_q;
  assign pc_d         = pc_id_q;
  assign pc_plus4_d   = pc4_id_q;
  assign valid_d      = valid_id_q;
  assign fetch_err    = ferr_q;
  assign misalign_err = merr_q;
  assign fetch_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A driver applies directed
//            control vectors and pushes the expected post-edge state into a
//            queue; a monitor pops and compares after each rising edge.
//            Spot checks against hand-written constants cover the key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'd0;
  logic [31:0] imem_addr, imem_rd, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, fault_f, fetch_err, misalign_err;

  logic [31:0] mem [0:20];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic        ferr;
    logic        merr;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_valid, m_ferr, m_merr;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .pc_f         (pc_f),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .fault_f      (fault_f),
    .fetch_err    (fetch_err),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a[31:2] < 30'd21) return mem[a[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_rd = mem_read(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of controls, advance the reference model, queue result.
  task automatic step(input logic rn, input logic sf, input logic sd,
                      input logic fd, input logic src, input logic [31:0] tgt);
    logic fault;
    logic [31:0] npc;
    exp_t e;
    @(negedge clk);
    rst_n = rn; stall_f = sf; stall_d = sd; flush_d = fd;
    pc_src_e = src; pc_target_e = tgt;
    if (!rn) begin
      m_pc = 32'd0; m_instr = c_nop; m_pcd = 32'd0; m_pc4 = 32'd0;
      m_valid = 1'b0; m_ferr = 1'b0; m_merr = 1'b0; m_cnt = 32'd0;
    end else begin
      fault = (m_pc >= 32'd84);
      if (src) npc = {tgt[31:2], 2'b00};
      else if (sf) npc = m_pc;
      else npc = m_pc + 32'd4;
      if (src && tgt[1:0] != 2'b00) m_merr = 1'b1;
      if (fd) begin
        m_instr = c_nop; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!sd) begin
        m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
        if (fault) begin
          m_instr = c_nop; m_valid = 1'b0; m_ferr = 1'b1;
        end else begin
          m_instr = mem_read(m_pc); m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
      end
      m_pc = npc;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4;
    e.valid = m_valid; e.fault = (m_pc >= 32'd84); e.ferr = m_ferr;
    e.merr = m_merr; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the queued expectation after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pc_f", pc_f, e.pc);
      chk("sb_imem_addr", imem_addr, e.pc);
      chk("sb_instr_d", instr_d, e.instr);
      chk("sb_pc_d", pc_d, e.pcd);
      chk("sb_pc_plus4_d", pc_plus4_d, e.pc4);
      chk1("sb_valid_d", valid_d, e.valid);
      chk1("sb_fault_f", fault_f, e.fault);
      chk1("sb_fetch_err", fetch_err, e.ferr);
      chk1("sb_misalign_err", misalign_err, e.merr);
      chk("sb_fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    logic [31:0] cnt_save;
    mem = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233,
            32'h0041F2B3, 32'h004282B3, 32'h02728863, 32'h0041A233,
            32'h00020463, 32'h00000293, 32'h0023A233, 32'h005203B3,
            32'h402383B3, 32'h0471AA23, 32'h06002103, 32'h005104B3,
            32'h008001EF, 32'h00100113, 32'h0221A023, 32'h00910133,
            32'h00210063};

    // Reset
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    after_edge();
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_instr_d", instr_d, c_nop);
    chk1("rst_valid_d", valid_d, 1'b0);
    chk("rst_count", fetch_count, 32'd0);

    // First two fetches
    run(1);
    after_edge();
    chk("e1_instr_d", instr_d, 32'h00500113);
    chk("e1_pc_d", pc_d, 32'h0);
    chk("e1_pc_plus4_d", pc_plus4_d, 32'h4);
    chk1("e1_valid_d", valid_d, 1'b1);
    chk("e1_pc_f", pc_f, 32'h4);
    run(1);
    after_edge();
    chk("e2_instr_d", instr_d, 32'h00C00193);
    chk("e2_count", fetch_count, 32'd2);

    // Full stall for 3 cycles at pc 0x8
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    after_edge();
    chk("stall_pc_f", pc_f, 32'h8);
    chk("stall_instr_d", instr_d, 32'h00C00193);
    run(1);
    after_edge();
    chk("unstall_instr_d", instr_d, 32'hFF718393);

    // Advance to 0x1C, then taken branch to 0x48 with flush
    run(4);
    after_edge();
    chk("pre_br_pc_f", pc_f, 32'h1C);
    cnt_save = fetch_count;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0048);
    after_edge();
    chk("br_pc_f", pc_f, 32'h48);
    chk("br_instr_d", instr_d, c_nop);
    chk1("br_valid_d", valid_d, 1'b0);
    chk("br_count", fetch_count, cnt_save);
    run(1);
    after_edge();
    chk("br_tgt_instr_d", instr_d, 32'h0221A023);
    chk("br_tgt_pc_d", pc_d, 32'h48);

    // Misaligned redirect to 0x4A
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_004A);
    after_edge();
    chk("mis_pc_f", pc_f, 32'h48);
    chk1("mis_err", misalign_err, 1'b1);

    // Run off the end of memory
    run(3);
    after_edge();
    chk("end_pc_f", pc_f, 32'h54);
    chk1("end_fault_f", fault_f, 1'b1);
    chk1("mis_sticky", misalign_err, 1'b1);
    run(1);
    after_edge();
    chk("flt_instr_d", instr_d, c_nop);
    chk1("flt_valid_d", valid_d, 1'b0);
    chk("flt_pc_d", pc_d, 32'h54);
    chk1("flt_fetch_err", fetch_err, 1'b1);
    chk("flt_pc_f", pc_f, 32'h58);

    // PC wrap at the top of the address space
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(1);
    after_edge();
    chk("wrap_pc_f", pc_f, 32'h0);
    chk("wrap_pc_plus4_d", pc_plus4_d, 32'h0);
    chk1("wrap_valid_d", valid_d, 1'b0);

    // stall_f only: same instruction re-captured
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    after_edge();
    chk("sf_pc_f", pc_f, 32'h0);
    chk("sf_instr_d", instr_d, 32'h00500113);

    // flush beats stall
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    after_edge();
    chk1("fl_st_valid_d", valid_d, 1'b0);
    chk("fl_st_instr_d", instr_d, c_nop);

    // Mid-run reset with other controls active
    run(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
    after_edge();
    chk("mrst_pc_f", pc_f, 32'h0);
    chk("mrst_count", fetch_count, 32'd0);
    chk1("mrst_ferr", fetch_err, 1'b0);
    chk1("mrst_merr", misalign_err, 1'b0);
    run(3);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
